// File: rtl/std_ram_reader.sv
// Burst reader: streams cmd_len words from a fixed-latency RAM, starting at cmd_addr,
// through a small credit-protected output FIFO.
module std_ram_reader #(
    parameter int DW         = 32,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH),
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [AW-1:0]         addr_q;
    logic [AW:0]           rem_q;
    logic                  done_q;
    logic [CW-1:0]         count;
    logic [CW-1:0]         inflight;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DW-1:0]         fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic                  accept, credit_ok, issue_last;
    logic                  push, push_last, pop, fire_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign issue_last = (rem_q == (AW+1)'(1));
    // Credit: never issue more reads than the FIFO can absorb, ignoring this cycle's pop.
    assign credit_ok  = (int'(count) + int'(inflight)) < FIFO_DEPTH;
    assign accept     = cmd_valid & cmd_ready;
    assign pop        = out_valid & out_ready;
    assign fire_last  = pop & out_last;

    assign mem_wr_en = 1'b0;
    assign mem_addr  = addr_q;
    assign out_valid = (count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];
    assign busy      = (state != IDLE);
    assign done      = done_q;

    // Valid/last shift registers align each read with its returning RAM word.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign push      = mem_rd_en;
            assign push_last = issue_last;
            assign inflight  = '0;
        end else begin : g_latn
            logic [RD_LAT-1:0] vld_pipe, last_pipe;
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_pipe  <= '0;
                    last_pipe <= '0;
                end else begin
                    vld_pipe  <= RD_LAT'({vld_pipe, mem_rd_en});
                    last_pipe <= RD_LAT'({last_pipe, mem_rd_en & issue_last});
                end
            end
            assign push      = vld_pipe[RD_LAT-1];
            assign push_last = last_pipe[RD_LAT-1];
            always_comb begin
                inflight = '0;
                for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
            end
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        mem_rd_en = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_len != '0) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_rd_en = credit_ok;
                if (credit_ok && issue_last) state_nxt = DRAIN;
            end
            DRAIN: if (fire_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (accept && cmd_len == '0) || fire_last;
            if (accept) begin
                addr_q <= cmd_addr;
                rem_q  <= cmd_len;
            end else if (mem_rd_en) begin
                addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                rem_q  <= rem_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_last <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_dout;
                fifo_last[wr_ptr] <= push_last;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_std_ram_reader.sv
// Runs three readers (RD_LAT 0,1,2) on shared stimulus against RAM[i]=i models
// and a per-reader scoreboard of expected addresses and words.
module tb_std_ram_reader;
    logic clk, reset, cmd_valid, out_ready;
    logic [4:0] cmd_addr;
    logic [5:0] cmd_len;

    logic [2:0]       cmd_ready_w, mem_rd_en_w, mem_wr_en_w, out_valid_w, out_last_w, busy_w, done_w;
    logic [2:0][4:0]  mem_addr_w;
    logic [2:0][31:0] out_data_w;

    int n_chk = 0, n_fail = 0, cyc = 0;

    logic [32:0] exp_q  [3][$];
    logic [4:0]  addr_q [3][$];
    int iss[3] = '{0, 0, 0}, hs[3] = '{0, 0, 0}, dn_cnt[3] = '{0, 0, 0};
    int done_cyc[3], fv[3], lv[3];
    logic [31:0] first_d[3], last_d[3], held_d[3];
    bit held_l[3], prev_stall[3], was_valid[3], first_pend[3];

    typedef struct {
        logic [4:0]  addr;
        logic [5:0]  len;
        int          bp;
        logic [31:0] first_w;
        logic [31:0] last_w;
    } vec_t;
    vec_t vt[8];

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic [31:0] dout;
        if (k == 0) begin : g_l0
            assign dout = mem_rd_en_w[k] ? 32'(mem_addr_w[k]) : 32'hDEAD_BEEF;
        end else if (k == 1) begin : g_l1
            logic [31:0] p1;
            always @(posedge clk) p1 <= mem_rd_en_w[k] ? 32'(mem_addr_w[k]) : 32'hDEAD_BEEF;
            assign dout = p1;
        end else begin : g_l2
            logic [31:0] p1, p2;
            always @(posedge clk) begin
                p1 <= mem_rd_en_w[k] ? 32'(mem_addr_w[k]) : 32'hDEAD_BEEF;
                p2 <= p1;
            end
            assign dout = p2;
        end
        std_ram_reader #(.DW(32), .DEPTH(32), .RD_LAT(k), .FIFO_DEPTH(4)) u_dut (
            .clk(clk), .reset(reset),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[k]),
            .cmd_addr(cmd_addr), .cmd_len(cmd_len),
            .mem_rd_en(mem_rd_en_w[k]), .mem_wr_en(mem_wr_en_w[k]),
            .mem_addr(mem_addr_w[k]), .mem_dout(dout),
            .out_valid(out_valid_w[k]), .out_ready(out_ready),
            .out_data(out_data_w[k]), .out_last(out_last_w[k]),
            .busy(busy_w[k]), .done(done_w[k])
        );
    end

    task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_eq(input string nm, input longint act, input longint exp);
        chk(nm, act == exp, act, exp);
    endtask

    always @(negedge clk) begin
        logic [4:0]  a;
        logic [32:0] e;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                exp_q[k].delete();
                addr_q[k].delete();
                iss[k] = hs[k];
                prev_stall[k] = 0;
                was_valid[k] = 0;
                first_pend[k] = 1;
            end else begin
                if (mem_rd_en_w[k]) begin
                    chk($sformatf("k%0d_rd_expected", k), addr_q[k].size() != 0, addr_q[k].size(), 1);
                    if (addr_q[k].size() != 0) begin
                        a = addr_q[k].pop_front();
                        chk_eq($sformatf("k%0d_rd_addr", k), mem_addr_w[k], a);
                    end
                    iss[k]++;
                    chk($sformatf("k%0d_outstanding", k), iss[k] - hs[k] <= 4, iss[k] - hs[k], 4);
                end
                if (prev_stall[k]) begin
                    chk_eq($sformatf("k%0d_hold_valid", k), out_valid_w[k], 1);
                    chk_eq($sformatf("k%0d_hold_data", k), out_data_w[k], held_d[k]);
                    chk_eq($sformatf("k%0d_hold_last", k), out_last_w[k], held_l[k]);
                end
                if (out_valid_w[k] && !was_valid[k]) fv[k] = cyc;
                if (out_valid_w[k] && out_ready) begin
                    chk($sformatf("k%0d_word_expected", k), exp_q[k].size() != 0, exp_q[k].size(), 1);
                    if (exp_q[k].size() != 0) begin
                        e = exp_q[k].pop_front();
                        chk_eq($sformatf("k%0d_data", k), out_data_w[k], e[31:0]);
                        chk_eq($sformatf("k%0d_last", k), out_last_w[k], e[32]);
                    end
                    hs[k]++;
                    if (first_pend[k]) begin
                        first_d[k] = out_data_w[k];
                        first_pend[k] = 0;
                    end
                    if (out_last_w[k]) begin
                        lv[k] = cyc;
                        last_d[k] = out_data_w[k];
                        first_pend[k] = 1;
                    end
                end
                if (done_w[k]) begin
                    dn_cnt[k]++;
                    done_cyc[k] = cyc;
                end
                prev_stall[k] = out_valid_w[k] && !out_ready;
                held_d[k] = out_data_w[k];
                held_l[k] = out_last_w[k];
                was_valid[k] = out_valid_w[k];
            end
        end
    end

    task automatic check_idle_outs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk_eq($sformatf("%s_k%0d_cmd_ready", tag, k), cmd_ready_w[k], 1);
            chk_eq($sformatf("%s_k%0d_mem_rd_en", tag, k), mem_rd_en_w[k], 0);
            chk_eq($sformatf("%s_k%0d_mem_wr_en", tag, k), mem_wr_en_w[k], 0);
            chk_eq($sformatf("%s_k%0d_mem_addr", tag, k), mem_addr_w[k], 0);
            chk_eq($sformatf("%s_k%0d_out_valid", tag, k), out_valid_w[k], 0);
            chk_eq($sformatf("%s_k%0d_out_data", tag, k), out_data_w[k], 0);
            chk_eq($sformatf("%s_k%0d_out_last", tag, k), out_last_w[k], 0);
            chk_eq($sformatf("%s_k%0d_busy", tag, k), busy_w[k], 0);
            chk_eq($sformatf("%s_k%0d_done", tag, k), done_w[k], 0);
        end
    endtask

    task automatic start_cmd(input logic [4:0] a, input logic [5:0] l, output int c0);
        int t = 0;
        while (!(&cmd_ready_w) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk_eq("cmd_ready_wait", cmd_ready_w, 7);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < int'(l); i++) begin
                exp_q[k].push_back({(i == int'(l) - 1), 32'((int'(a) + i) % 32)});
                addr_q[k].push_back(5'((int'(a) + i) % 32));
            end
        cmd_valid = 1;
        cmd_addr  = a;
        cmd_len   = l;
        c0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic run_burst(input int idx, input vec_t v);
        int c0, t, d0[3];
        bit all;
        for (int k = 0; k < 3; k++) d0[k] = dn_cnt[k];
        out_ready = (v.bp == 0);
        start_cmd(v.addr, v.len, c0);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk_eq($sformatf("v%0d_k%0d_busy", idx, k), busy_w[k], v.len != 0);
        t = 0;
        all = 0;
        while (!all && t < 400) begin
            @(posedge clk); #1;
            t++;
            if (t >= v.bp) out_ready = 1;
            all = (dn_cnt[0] > d0[0]) && (dn_cnt[1] > d0[1]) && (dn_cnt[2] > d0[2]);
        end
        chk($sformatf("v%0d_completed", idx), all, t, 400);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_eq($sformatf("v%0d_k%0d_done_cnt", idx, k), dn_cnt[k] - d0[k], 1);
            chk_eq($sformatf("v%0d_k%0d_words_left", idx, k), exp_q[k].size(), 0);
            chk_eq($sformatf("v%0d_k%0d_reads_left", idx, k), addr_q[k].size(), 0);
            if (v.len != 0) begin
                chk_eq($sformatf("v%0d_k%0d_first_lat", idx, k), fv[k] - c0, 2 + k);
                chk_eq($sformatf("v%0d_k%0d_done_lat", idx, k), done_cyc[k] - lv[k], 1);
                chk_eq($sformatf("v%0d_k%0d_first_word", idx, k), first_d[k], v.first_w);
                chk_eq($sformatf("v%0d_k%0d_last_word", idx, k), last_d[k], v.last_w);
                if (v.bp == 0)
                    chk_eq($sformatf("v%0d_k%0d_span", idx, k), lv[k] - fv[k], int'(v.len) - 1);
            end else begin
                chk_eq($sformatf("v%0d_k%0d_done_lat", idx, k), done_cyc[k] - c0, 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, t, h0, d0[3];
        reset = 1; cmd_valid = 0; cmd_addr = 0; cmd_len = 0; out_ready = 1;
        vt[0] = '{5'd3,  6'd4,  0,  32'd3,  32'd6};
        vt[1] = '{5'd30, 6'd4,  0,  32'd30, 32'd1};
        vt[2] = '{5'd10, 6'd8,  10, 32'd10, 32'd17};
        vt[3] = '{5'd0,  6'd0,  0,  32'd0,  32'd0};
        vt[4] = '{5'd5,  6'd32, 0,  32'd5,  32'd4};
        vt[5] = '{5'd31, 6'd1,  3,  32'd31, 32'd31};
        vt[6] = '{5'd17, 6'd5,  2,  32'd17, 32'd21};
        vt[7] = '{5'd2,  6'd3,  0,  32'd2,  32'd4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outs("reset");
        @(posedge clk); #1;
        reset = 0;

        for (int i = 0; i < 7; i++) run_burst(i, vt[i]);

        // Abort a len=6 burst while the second word is on the output.
        for (int k = 0; k < 3; k++) d0[k] = dn_cnt[k];
        start_cmd(5'd8, 6'd6, c0);
        h0 = hs[1] - ((hs[1] > 0 && fv[1] == c0 + 3) ? 1 : 0);
        t = 0;
        while (hs[1] < h0 + 1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("midrst_wait", hs[1] >= h0 + 1, hs[1] - h0, 1);
        reset = 1;
        out_ready = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check_idle_outs("midrst");
        out_ready = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_eq($sformatf("midrst_k%0d_no_done", k), dn_cnt[k], d0[k]);
            chk_eq($sformatf("midrst_k%0d_idle", k), busy_w[k], 0);
        end

        run_burst(7, vt[7]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
